// File: rtl/lzd_normalizer_if.sv
// Start/busy/done handshake bundle shared with the leading-zero detector:
// operand, direction and shift distance in, shifted word and sticky out.
interface lzd_normalizer_if #(
   parameter int width       = 64,
   parameter int count_width = 7
);
   logic                   start;
   logic                   dir;
   logic [width-1:0]       data_in;
   logic [count_width-1:0] shift_amt;
   logic [width-1:0]       data_out;
   logic                   shifted_out;
   logic                   busy;
   logic                   done;

   // Requester side: issues operations and observes results.
   modport master (
      output start, dir, data_in, shift_amt,
      input  data_out, shifted_out, busy, done
   );

   // Shifter side.
   modport slave (
      input  start, dir, data_in, shift_amt,
      output data_out, shifted_out, busy, done
   );
endinterface

// File: rtl/lzd_normalizer.sv
// Multicycle barrel shifter. Applies a (clamped) shift distance to a word
// using coarse strides of `step` bits and single-bit steps for the remainder.
// Left shifts normalise a mantissa; right shifts denormalise and collect a
// sticky bit. Every bit pushed out of the word is ORed into shifted_out.
module lzd_normalizer #(
   parameter int width       = 64,
   parameter int count_width = 7,
   parameter int step        = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   lzd_normalizer_if.slave     bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [count_width-1:0] WIDTH_C = count_width'(width);
   localparam logic [count_width-1:0] STEP_C  = count_width'(step);
   localparam logic [count_width-1:0] ONE_C   = count_width'(1);

   state_t                 state_q, state_d;
   logic [width-1:0]       work_q, work_d;
   logic                   dir_q, dir_d;
   logic [count_width-1:0] remaining_q, remaining_d;
   logic                   sticky_q, sticky_d;
   logic [width-1:0]       data_out_q, data_out_d;
   logic                   shifted_out_q, shifted_out_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   // Requested distance limited to the word width; anything larger empties the word.
   logic [count_width-1:0] clamped_amt;
   assign clamped_amt = (bus.shift_amt >= WIDTH_C) ? WIDTH_C : bus.shift_amt;

   // Shift candidates for this cycle and the bits each one would push out.
   logic [width-1:0] coarse_word, fine_word;
   logic             coarse_lost, fine_lost;
   logic             use_coarse;

   // Select shifted words and lost bits for both stride sizes in the latched direction.
   always_comb begin
      if (dir_q) begin
         coarse_word = work_q >> step;
         fine_word   = work_q >> 1;
         coarse_lost = |work_q[step-1:0];
         fine_lost   = work_q[0];
      end else begin
         coarse_word = work_q << step;
         fine_word   = work_q << 1;
         coarse_lost = |work_q[width-1 -: step];
         fine_lost   = work_q[width-1];
      end
      use_coarse = (remaining_q >= STEP_C);
   end

   // Next-state and next-output logic for the IDLE/SHIFT/DONE sequence.
   always_comb begin
      state_d       = state_q;
      work_d        = work_q;
      dir_d         = dir_q;
      remaining_d   = remaining_q;
      sticky_d      = sticky_q;
      data_out_d    = data_out_q;
      shifted_out_d = shifted_out_q;
      busy_d        = busy_q;
      done_d        = done_q;

      case (state_q)
         IDLE: begin
            if (bus.start && !busy_q) begin
               work_d      = bus.data_in;
               dir_d       = bus.dir;
               remaining_d = clamped_amt;
               sticky_d    = 1'b0;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               state_d     = (clamped_amt != '0) ? SHIFT : DONE;
            end else begin
               done_d = 1'b0;
            end
         end

         SHIFT: begin
            // The chosen stride never exceeds remaining, so it cannot underflow.
            if (use_coarse) begin
               work_d      = coarse_word;
               sticky_d    = sticky_q | coarse_lost;
               remaining_d = remaining_q - STEP_C;
            end else begin
               work_d      = fine_word;
               sticky_d    = sticky_q | fine_lost;
               remaining_d = remaining_q - ONE_C;
            end
            if (remaining_d == '0) begin
               state_d = DONE;
            end
         end

         DONE: begin
            data_out_d    = work_q;
            shifted_out_d = sticky_q;
            done_d        = 1'b1;
            busy_d        = 1'b0;
            state_d       = IDLE;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   // State register with synchronous active-low reset; reset aborts any operation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         work_q        <= '0;
         dir_q         <= 1'b0;
         remaining_q   <= '0;
         sticky_q      <= 1'b0;
         data_out_q    <= '0;
         shifted_out_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         work_q        <= work_d;
         dir_q         <= dir_d;
         remaining_q   <= remaining_d;
         sticky_q      <= sticky_d;
         data_out_q    <= data_out_d;
         shifted_out_q <= shifted_out_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign bus.data_out    = data_out_q;
   assign bus.shifted_out = shifted_out_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;

endmodule

// File: tb/tb_lzd_normalizer.sv
// Self-checking bench for lzd_normalizer: directed cases with literal
// expectations plus randomized operations compared every cycle against a
// transaction-level model (result from plain shift arithmetic, timing from
// the closed-form latency).
module tb_lzd_normalizer;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   lzd_normalizer_if #(.width(64), .count_width(7)) bus ();

   lzd_normalizer #(.width(64), .count_width(7), .step(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected result of a complete shift, straight from the definition.
   function automatic void model_result(input logic d, input logic [63:0] x, input int amt,
                                        output logic [63:0] o, output logic s);
      int r;
      r = (amt > 64) ? 64 : amt;
      if (r == 0) begin
         o = x; s = 1'b0;
      end else if (r == 64) begin
         o = '0; s = |x;
      end else if (!d) begin
         o = x << r; s = |(x >> (64 - r));
      end else begin
         o = x >> r; s = |(x << (64 - r));
      end
   endfunction

   // Edges from acceptance (edge 0) until done is visible.
   function automatic int model_latency(input int amt);
      int r;
      r = (amt > 64) ? 64 : amt;
      return r / 8 + r % 8 + 1;
   endfunction

   // Transaction-level model state.
   logic        m_valid;
   logic        m_busy, m_done, m_sh, p_sh;
   logic [63:0] m_out, p_out;
   int          m_cnt, m_lat;

   initial begin
      m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_sh = 1'b0; p_sh = 1'b0;
      m_out = '0; p_out = '0; m_cnt = 0; m_lat = 0;
   end

   // Advance the model at each active edge using the inputs the DUT sees.
   always @(posedge clk) begin
      if (!rst_n) begin
         m_valid = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_out = '0; m_sh = 1'b0;
      end else if (m_busy) begin
         m_cnt++;
         if (m_cnt == m_lat) begin
            m_busy = 1'b0; m_done = 1'b1; m_out = p_out; m_sh = p_sh;
         end
      end else if (bus.start) begin
         model_result(bus.dir, bus.data_in, int'(bus.shift_amt), p_out, p_sh);
         m_lat  = model_latency(int'(bus.shift_amt));
         m_cnt  = 0;
         m_busy = 1'b1;
         m_done = 1'b0;
      end else begin
         m_done = 1'b0;
      end
   end

   // Compare process: every output checked against the model on every cycle.
   always @(negedge clk) begin
      if (m_valid) begin
         checks++;
         if (bus.busy !== m_busy || bus.done !== m_done ||
             bus.data_out !== m_out || bus.shifted_out !== m_sh) begin
            errors++;
            $display("FAIL cycle_model t=%0t got busy=%b done=%b out=%h sh=%b expected busy=%b done=%b out=%h sh=%b",
                     $time, bus.busy, bus.done, bus.data_out, bus.shifted_out,
                     m_busy, m_done, m_out, m_sh);
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one operation and wait (bounded) for done; returns observed latency.
   // While busy, optionally throws in ignored start requests with junk data.
   task automatic run_op(input logic d, input logic [63:0] x, input int amt,
                         input bit skip_gap, input bit noise, output int lat);
      int n;
      if (!skip_gap) @(negedge clk);
      bus.start = 1'b1; bus.dir = d; bus.data_in = x; bus.shift_amt = 7'(amt);
      @(negedge clk);
      bus.start = 1'b0;
      n = 0;
      while (!bus.done && n < 40) begin
         if (noise && ($urandom_range(0, 3) == 0)) begin
            bus.start = 1'b1; bus.dir = $urandom_range(0, 1);
            bus.data_in = {$urandom, $urandom}; bus.shift_amt = 7'($urandom_range(0, 127));
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      bus.start = 1'b0;
      if (n >= 40) begin
         checks++; errors++;
         $display("FAIL done_timeout got no done within 40 cycles expected done");
      end
      lat = n;
   endtask

   task automatic directed(input string name, input logic d, input logic [63:0] x, input int amt,
                           input logic [63:0] exp_out, input logic exp_sh, input int exp_lat);
      int lat;
      logic [63:0] mo;
      logic ms;
      run_op(d, x, amt, 1'b0, 1'b0, lat);
      chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({name, "_data_out"}, bus.data_out, exp_out);
      chk({name, "_shifted_out"}, {63'd0, bus.shifted_out}, {63'd0, exp_sh});
      // Pin the model to the same literal expectations.
      model_result(d, x, amt, mo, ms);
      chk({name, "_model_out"}, mo, exp_out);
      chk({name, "_model_lat"}, 64'(model_latency(amt)), 64'(exp_lat));
      $display("op %s dir=%0d in=%h amt=%0d -> out=%h sh=%b lat=%0d", name, d, x, amt,
               bus.data_out, bus.shifted_out, lat);
   endtask

   initial begin
      int          lat;
      int          busy_cycles;
      logic [63:0] x;
      logic [63:0] first_exp;
      checks = 0; errors = 0;
      rst_n = 1'b0; bus.start = 1'b0; bus.dir = 1'b0; bus.data_in = '0; bus.shift_amt = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", {63'd0, bus.busy}, 64'd0);
      chk("reset_done", {63'd0, bus.done}, 64'd0);
      chk("reset_data_out", bus.data_out, 64'd0);
      chk("reset_shifted_out", {63'd0, bus.shifted_out}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Zero shift: also verify busy is high exactly one cycle.
      bus.start = 1'b1; bus.dir = 1'b0; bus.data_in = 64'h1234; bus.shift_amt = 7'd0;
      @(negedge clk);
      bus.start = 1'b0;
      busy_cycles = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus.busy) busy_cycles++;
         @(negedge clk);
      end
      chk("zero_busy_cycles", 64'(busy_cycles), 64'd1);
      chk("zero_data_out", bus.data_out, 64'h1234);
      $display("op zero_shift out=%h sh=%b busy_cycles=%0d", bus.data_out, bus.shifted_out, busy_cycles);

      directed("zero",      1'b0, 64'h0000_0000_0000_1234, 0,   64'h0000_0000_0000_1234, 1'b0, 1);
      directed("norm56",    1'b0, 64'h0000_0000_0000_00F0, 56,  64'hF000_0000_0000_0000, 1'b0, 8);
      directed("right9",    1'b1, 64'h8000_0000_0000_0001, 9,   64'h0040_0000_0000_0000, 1'b1, 3);
      directed("clamp100",  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 100, 64'h0,                   1'b1, 9);
      directed("left63",    1'b0, 64'h0000_0000_0000_0001, 63,  64'h8000_0000_0000_0000, 1'b0, 15);
      directed("right64",   1'b1, 64'h0000_0000_0000_0001, 64,  64'h0,                   1'b1, 9);
      directed("zero_data", 1'b1, 64'h0,                   37,  64'h0,                   1'b0, 10);
      directed("left_lost", 1'b0, 64'h4000_0000_0000_0000, 2,   64'h0,                   1'b1, 3);

      // Handshake: starts while busy (including the DONE cycle) are ignored;
      // the held start is accepted in the cycle after done.
      @(negedge clk);
      bus.start = 1'b1; bus.dir = 1'b0; bus.data_in = 64'h0000_0000_0000_00AB; bus.shift_amt = 7'd16;
      @(negedge clk);                       // edge 0 accepted
      first_exp = 64'h0000_0000_00AB_0000;
      bus.data_in = 64'h0000_0000_0000_0F0F; bus.shift_amt = 7'd4;   // keep start high
      @(negedge clk);                       // edge 1
      @(negedge clk);                       // edge 2 (now DONE)
      @(negedge clk);                       // edge 3: done, start coincident with DONE ignored
      chk("hs_done", {63'd0, bus.done}, 64'd1);
      chk("hs_first_result", bus.data_out, first_exp);
      @(negedge clk);                       // edge 4: held start accepted
      bus.start = 1'b0;
      chk("hs_busy_after_accept", {63'd0, bus.busy}, 64'd1);
      chk("hs_done_cleared", {63'd0, bus.done}, 64'd0);
      lat = 0;
      while (!bus.done && lat < 40) begin @(negedge clk); lat++; end
      chk("hs_second_result", bus.data_out, 64'h0000_0000_0000_F0F0);
      $display("op handshake first=%h second=%h", first_exp, bus.data_out);

      // Reset in the middle of a 40-bit shift.
      @(negedge clk);
      bus.start = 1'b1; bus.dir = 1'b1; bus.data_in = 64'hDEAD_BEEF_0123_4567; bus.shift_amt = 7'd40;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
      chk("rst_mid_done", {63'd0, bus.done}, 64'd0);
      chk("rst_mid_data_out", bus.data_out, 64'd0);
      chk("rst_mid_shifted_out", {63'd0, bus.shifted_out}, 64'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("rst_no_done", {63'd0, bus.done}, 64'd0);
      end
      $display("op reset_mid_shift busy=%b done=%b", bus.busy, bus.done);
      directed("after_rst", 1'b1, 64'hDEAD_BEEF_0123_4567, 40, 64'h0000_0000_00DE_ADBE, 1'b1, 6);

      // Randomized operations, checked cycle by cycle by the model.
      for (int k = 0; k < 150; k++) begin
         case ($urandom_range(0, 3))
            0: x = {$urandom, $urandom};
            1: x = 64'd1 << $urandom_range(0, 63);
            2: x = 64'd0;
            default: x = {$urandom, $urandom} >> $urandom_range(0, 63);
         endcase
         run_op($urandom_range(0, 1), x, $urandom_range(0, 127),
                ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), lat);
         $display("op rand%0d in=%h -> out=%h sh=%b lat=%0d", k, x, bus.data_out, bus.shifted_out, lat);
      end

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
